// File: rtl/acc_sequencer.sv
// rtl/acc_sequencer.sv - control sequencer for the 4-bit ALU accumulator datapath
//
// Purpose:
//    Accepts one command at a time over a Start/Ready/Done handshake and walks
//    the datapath through a fixed strobe order. ADD/SUB run a single pass,
//    CLR pulses the accumulator clear, and MAC repeats B <= B + A Count times
//    by routing the ALU result back into B.
//
// Ports:
//    MainClock    in   system clock, rising edge
//    Clear        in   synchronous active-high reset, beats every other input
//    Start        in   command request, sampled only while Ready=1
//    Op           in   00 ADD, 01 SUB, 10 MAC, 11 CLR
//    Count        in   MAC iteration count (0 behaves as 1)
//    Ready        out  high only while idle
//    Done         out  one-cycle completion pulse
//    LatchA       out  load strobe for operand register A
//    LatchB       out  load strobe for accumulator B
//    ClearB       out  active-low clear for accumulator B
//    SelFeedback  out  B input mux: 0 external bus, 1 ALU result
//    AluOp        out  ALU function: 00 add, 01 sub
//    LatchOut     out  result latch strobe
//    Iter         out  completed WRITE cycles of the current command

module acc_sequencer #(
   parameter int CNT_W = 4,
   parameter int OP_W  = 2
) (
   input  logic             MainClock,
   input  logic             Clear,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [CNT_W-1:0] Count,
   output logic             Ready,
   output logic             Done,
   output logic             LatchA,
   output logic             LatchB,
   output logic             ClearB,
   output logic             SelFeedback,
   output logic [OP_W-1:0]  AluOp,
   output logic             LatchOut,
   output logic [CNT_W-1:0] Iter
);

   typedef enum logic [2:0] {
      IDLE,
      CLRB,
      LOADA,
      LOADB,
      EXEC,
      WRITE,
      FEEDBK,
      DONE
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MAC = 2'b10;
   localparam logic [1:0] OP_CLR = 2'b11;

   localparam logic [OP_W-1:0]  ALU_ADD  = '0;
   localparam logic [OP_W-1:0]  ALU_SUB  = OP_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] ITER_MAX = '1;

   state_t           state;
   state_t           stateNext;
   logic [1:0]       opReg;
   logic [CNT_W-1:0] remaining;
   logic [CNT_W-1:0] iterReg;
   logic             captureCmd;
   logic             moreIter;

   assign captureCmd = (state == IDLE) && Start;

   // Another feedback round is needed only for MAC while passes are left after this WRITE.
   assign moreIter = (opReg == OP_MAC) && (remaining > CNT_ONE);

   always_ff @(posedge MainClock) begin
      if (Clear) begin
         state     <= IDLE;
         opReg     <= OP_ADD;
         remaining <= '0;
         iterReg   <= '0;
      end else begin
         state <= stateNext;
         if (captureCmd) begin
            opReg     <= Op;
            // A zero count still runs one pass rather than wrapping to 2^CNT_W.
            remaining <= (Count == '0) ? CNT_ONE : Count;
            iterReg   <= '0;
         end else if (state == WRITE) begin
            if (iterReg != ITER_MAX) begin
               iterReg <= iterReg + CNT_ONE;
            end
            if (moreIter) begin
               remaining <= remaining - CNT_ONE;
            end
         end
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (Start) begin
               stateNext = (Op == OP_CLR) ? CLRB : LOADA;
            end
         end
         CLRB:    stateNext = DONE;
         LOADA:   stateNext = LOADB;
         LOADB:   stateNext = EXEC;
         EXEC:    stateNext = WRITE;
         WRITE:   stateNext = moreIter ? FEEDBK : DONE;
         FEEDBK:  stateNext = EXEC;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Moore decode: every output is a function of registered state only.
   always_comb begin
      Ready       = 1'b0;
      Done        = 1'b0;
      LatchA      = 1'b0;
      LatchB      = 1'b0;
      ClearB      = 1'b1;
      SelFeedback = 1'b0;
      LatchOut    = 1'b0;
      AluOp       = ALU_ADD;
      case (state)
         IDLE:   Ready  = 1'b1;
         CLRB:   ClearB = 1'b0;
         LOADA:  LatchA = 1'b1;
         LOADB:  LatchB = 1'b1;
         WRITE:  LatchOut = 1'b1;
         FEEDBK: begin
            LatchB      = 1'b1;
            SelFeedback = 1'b1;
         end
         DONE:   Done = 1'b1;
         default: ;
      endcase
      // ALU function is held steady across the whole LOADA..WRITE window, feedback rounds included.
      if ((state == LOADA || state == LOADB || state == EXEC ||
           state == WRITE || state == FEEDBK) && (opReg == OP_SUB)) begin
         AluOp = ALU_SUB;
      end
   end

   assign Iter = iterReg;

endmodule

// File: tb/tb_acc_sequencer.sv
// tb/tb_acc_sequencer.sv - self-checking bench for acc_sequencer

module tb_acc_sequencer;

   logic       MainClock;
   logic       Clear;
   logic       Start;
   logic [1:0] Op;
   logic [3:0] Count;
   logic       Ready;
   logic       Done;
   logic       LatchA;
   logic       LatchB;
   logic       ClearB;
   logic       SelFeedback;
   logic [1:0] AluOp;
   logic       LatchOut;
   logic [3:0] Iter;

   int nChecks = 0;
   int nFail   = 0;

   acc_sequencer #(.CNT_W(4), .OP_W(2)) dut (
      .MainClock   (MainClock),
      .Clear       (Clear),
      .Start       (Start),
      .Op          (Op),
      .Count       (Count),
      .Ready       (Ready),
      .Done        (Done),
      .LatchA      (LatchA),
      .LatchB      (LatchB),
      .ClearB      (ClearB),
      .SelFeedback (SelFeedback),
      .AluOp       (AluOp),
      .LatchOut    (LatchOut),
      .Iter        (Iter)
   );

   initial begin
      MainClock = 1'b0;
      forever #5 MainClock = ~MainClock;
   end

   typedef struct packed {
      logic       ready;
      logic       done;
      logic       latchA;
      logic       latchB;
      logic       clearB;
      logic       selFb;
      logic [1:0] aluOp;
      logic       latchOut;
      logic [3:0] iter;
   } obs_t;

   obs_t obs;
   assign obs = {Ready, Done, LatchA, LatchB, ClearB, SelFeedback, AluOp, LatchOut, Iter};

   obs_t expQ[$];

   // Small datapath model driven by the DUT strobes.
   logic [3:0] busA, busB;
   logic [3:0] dpA, dpB, dpOut;
   logic [3:0] aluRes;
   assign aluRes = (AluOp == 2'b01) ? dpB - dpA : dpB + dpA;

   always @(posedge MainClock) begin
      if (LatchA)   dpA <= busA;
      if (LatchB)   dpB <= SelFeedback ? aluRes : busB;
      if (!ClearB)  dpB <= 4'd0;
      if (LatchOut) dpOut <= aluRes;
   end

   function automatic obs_t mk(bit rdy, bit dn, bit la, bit lb, bit clrb, bit sel,
                               logic [1:0] aop, bit lo, logic [3:0] it);
      return {rdy, dn, la, lb, clrb, sel, aop, lo, it};
   endfunction

   // Expected per-cycle trace, starting the cycle after the capture edge.
   task automatic buildTrace(input logic [1:0] op, input logic [3:0] cnt);
      logic [1:0] aop;
      int n;
      expQ.delete();
      if (op == 2'b11) begin
         expQ.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 4'd0));
         expQ.push_back(mk(0, 1, 0, 0, 1, 0, 2'b00, 0, 4'd0));
      end else begin
         aop = (op == 2'b01) ? 2'b01 : 2'b00;
         n   = (op == 2'b10 && cnt != 0) ? int'(cnt) : 1;
         expQ.push_back(mk(0, 0, 1, 0, 1, 0, aop, 0, 4'd0));
         expQ.push_back(mk(0, 0, 0, 1, 1, 0, aop, 0, 4'd0));
         expQ.push_back(mk(0, 0, 0, 0, 1, 0, aop, 0, 4'd0));
         for (int i = 1; i <= n; i++) begin
            expQ.push_back(mk(0, 0, 0, 0, 1, 0, aop, 1, 4'(i - 1)));
            if (i < n) begin
               expQ.push_back(mk(0, 0, 0, 1, 1, 1, aop, 0, 4'(i)));
               expQ.push_back(mk(0, 0, 0, 0, 1, 0, aop, 0, 4'(i)));
            end
         end
         expQ.push_back(mk(0, 1, 0, 0, 1, 0, 2'b00, 0, 4'(n)));
      end
   endtask

   task automatic stepCycle();
      @(posedge MainClock);
      #1;
   endtask

   // Issue one command, check every cycle against the trace, then the datapath result.
   task automatic runCmd(input logic [1:0] op, input logic [3:0] cnt, input bit noisy,
                         input logic [3:0] aVal, input logic [3:0] bVal, input string tag);
      int guard;
      int n;
      logic [3:0] expRes;
      logic [3:0] expIter;
      guard = 0;
      while (Ready !== 1'b1 && guard < 60) begin
         stepCycle();
         guard++;
      end
      if (Ready !== 1'b1) begin
         nChecks++;
         nFail++;
         $display("FAIL %s ready-timeout: Ready=%b required 1", tag, Ready);
         return;
      end
      busA  = aVal;
      busB  = bVal;
      Start = 1'b1;
      Op    = op;
      Count = cnt;
      buildTrace(op, cnt);
      for (int j = 0; j < expQ.size(); j++) begin
         stepCycle();
         Start = noisy ? 1'($urandom) : 1'b0;
         Op    = 2'($urandom);
         Count = 4'($urandom);
         nChecks++;
         if (obs !== expQ[j]) begin
            nFail++;
            $display("FAIL %s cycle %0d: got %b required %b", tag, j + 1, obs, expQ[j]);
         end
      end
      Start = 1'b0;
      stepCycle();
      n       = (op == 2'b10 && cnt != 0) ? int'(cnt) : 1;
      expIter = (op == 2'b11) ? 4'd0 : 4'(n);
      nChecks++;
      if (obs !== mk(1, 0, 0, 0, 1, 0, 2'b00, 0, expIter)) begin
         nFail++;
         $display("FAIL %s idle-after: got %b required %b", tag, obs,
                  mk(1, 0, 0, 0, 1, 0, 2'b00, 0, expIter));
      end
      nChecks++;
      if (op == 2'b11) begin
         if (dpB !== 4'd0) begin
            nFail++;
            $display("FAIL %s accB-cleared: got %0d required 0", tag, dpB);
         end
      end else begin
         case (op)
            2'b00:   expRes = bVal + aVal;
            2'b01:   expRes = bVal - aVal;
            default: expRes = 4'((int'(bVal) + n * int'(aVal)) & 15);
         endcase
         if (dpOut !== expRes) begin
            nFail++;
            $display("FAIL %s result: got %0d required %0d", tag, dpOut, expRes);
         end
      end
   endtask

   task automatic test_reset();
      Clear = 1'b1;
      stepCycle();
      stepCycle();
      Clear = 1'b0;
      nChecks++;
      if (obs !== mk(1, 0, 0, 0, 1, 0, 2'b00, 0, 4'd0)) begin
         nFail++;
         $display("FAIL reset-state: got %b required %b", obs, mk(1, 0, 0, 0, 1, 0, 2'b00, 0, 4'd0));
      end
      stepCycle();
      nChecks++;
      if (obs !== mk(1, 0, 0, 0, 1, 0, 2'b00, 0, 4'd0)) begin
         nFail++;
         $display("FAIL reset-hold: got %b required %b", obs, mk(1, 0, 0, 0, 1, 0, 2'b00, 0, 4'd0));
      end
   endtask

   task automatic test_add();
      runCmd(2'b00, 4'd7, 1'b0, 4'd3, 4'd5, "add");
   endtask

   task automatic test_sub();
      runCmd(2'b01, 4'd2, 1'b0, 4'd6, 4'd4, "sub");
   endtask

   task automatic test_clr();
      runCmd(2'b11, 4'd9, 1'b0, 4'd1, 4'd1, "clr");
   endtask

   task automatic test_mac();
      runCmd(2'b10, 4'd3, 1'b0, 4'd2, 4'd1, "mac3");
      nChecks++;
      if (dpOut !== 4'd7) begin
         nFail++;
         $display("FAIL mac3-final: got %0d required 7", dpOut);
      end
   endtask

   task automatic test_mac_zero();
      runCmd(2'b10, 4'd0, 1'b1, 4'd5, 4'd2, "mac0");
   endtask

   task automatic test_back_to_back();
      runCmd(2'b10, 4'd15, 1'b0, 4'd1, 4'd0, "b2b-mac15");
      runCmd(2'b00, 4'd0, 1'b0, 4'd9, 4'd9, "b2b-add");
      runCmd(2'b11, 4'd0, 1'b0, 4'd0, 4'd0, "b2b-clr");
   endtask

   task automatic test_random();
      for (int r = 0; r < 25; r++) begin
         runCmd(2'($urandom), 4'($urandom), 1'b1, 4'($urandom), 4'($urandom), "rand");
      end
   endtask

   task automatic test_clear_mid();
      bit strayStrobe;
      busA = 4'd1;
      busB = 4'd1;
      Start = 1'b1;
      Op    = 2'b10;
      Count = 4'd5;
      buildTrace(2'b10, 4'd5);
      for (int c = 1; c <= 6; c++) begin
         stepCycle();
         Start = 1'b0;
      end
      nChecks++;
      if (obs !== expQ[5]) begin
         nFail++;
         $display("FAIL clrmid-cycle6: got %b required %b", obs, expQ[5]);
      end
      Clear = 1'b1;
      stepCycle();
      nChecks++;
      if (obs !== mk(1, 0, 0, 0, 1, 0, 2'b00, 0, 4'd0)) begin
         nFail++;
         $display("FAIL clrmid-abort: got %b required %b", obs, mk(1, 0, 0, 0, 1, 0, 2'b00, 0, 4'd0));
      end
      Start = 1'b1;
      Op    = 2'b00;
      stepCycle();
      Clear = 1'b0;
      Start = 1'b0;
      nChecks++;
      if (obs !== mk(1, 0, 0, 0, 1, 0, 2'b00, 0, 4'd0)) begin
         nFail++;
         $display("FAIL clr-with-start: got %b required %b", obs, mk(1, 0, 0, 0, 1, 0, 2'b00, 0, 4'd0));
      end
      strayStrobe = 1'b0;
      for (int c = 0; c < 8; c++) begin
         stepCycle();
         if (Done !== 1'b0 || LatchA !== 1'b0 || Ready !== 1'b1) strayStrobe = 1'b1;
      end
      nChecks++;
      if (strayStrobe) begin
         nFail++;
         $display("FAIL clrmid-quiet: stray activity seen, required none");
      end
   endtask

   initial begin
      Clear = 1'b1;
      Start = 1'b0;
      Op    = 2'b00;
      Count = 4'd0;
      busA  = 4'd0;
      busB  = 4'd0;
      test_reset();
      test_add();
      test_sub();
      test_clr();
      test_mac();
      test_mac_zero();
      test_back_to_back();
      test_clear_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/acc_sequencer.md
Name: acc_sequencer

Overview:
- Control sequencer for the 4-bit ALU datapath: operand register A, accumulator register B (load/clear strobes) and the result latch.
- Accepts one command at a time through a Start/Ready/Done handshake.
- Generates the LatchA, LatchB, ClearB, AluOp, feedback-select and LatchOut strobes in a fixed order.
- Supports repeated accumulation (MAC mode: B <= B + A, N times), so small multiplies run by repeated addition without CPU involvement.

Parameters:
- CNT_W, 4, width of the iteration count and of the Iter counter.
- OP_W, 2, width of the AluOp bus.

Ports:
- MainClock  in  1  system clock; all state changes on the rising edge.
- Clear  in  1  synchronous, active-high reset.
- Start  in  1  command request; sampled only while Ready=1.
- Op  in  2  command: 00 ADD, 01 SUB, 10 MAC, 11 CLR.
- Count  in  CNT_W  MAC iteration count; ignored for other ops.
- Ready  out  1  high in IDLE only.
- Done  out  1  one-cycle pulse when a command completes.
- LatchA  out  1  load strobe for operand register A.
- LatchB  out  1  load strobe for accumulator B (ANDed with MainClock inside the accumulator).
- ClearB  out  1  active-low clear for accumulator B.
- SelFeedback  out  1  B input mux: 0 = external bus, 1 = ALU result.
- AluOp  out  OP_W  ALU function: 00 add, 01 sub.
- LatchOut  out  1  result latch strobe.
- Iter  out  CNT_W  number of completed WRITE cycles for the current command.

Behaviour:
- Interface: one clock (MainClock); reset (Clear) is synchronous and active-high.
- All outputs are Moore outputs decoded from registered state; they change only on MainClock edges.
- Reset values: state = IDLE, Ready=1, Done=0, LatchA=0, LatchB=0, ClearB=1, SelFeedback=0, AluOp=00, LatchOut=0, Iter=0, internal remaining=0.
- Clear has priority over every other input, including Start on the same edge.
- Clear mid-command returns the block to IDLE on the next edge with all strobes in their reset values. Partial datapath results are not restored.
- Command capture: an edge with Ready=1 and Start=1 registers Op and Count, sets Iter=0 and leaves IDLE.
- Start while Ready=0 is ignored; there is no queueing.
- States and transitions:
  - IDLE: Ready=1. On Start, go to CLRB if Op=11, else LOADA.
  - CLRB: ClearB=0 for exactly one cycle -> DONE.
  - LOADA: LatchA=1 -> LOADB.
  - LOADB: LatchB=1, SelFeedback=0 -> EXEC.
  - EXEC: no strobes; one ALU settle cycle -> WRITE.
  - WRITE: LatchOut=1; Iter increments.
    - If Op=MAC and remaining > 1: remaining decrements -> FEEDBK.
    - Otherwise -> DONE.
  - FEEDBK: LatchB=1, SelFeedback=1 (B <= ALU result) -> EXEC.
  - DONE: Done=1 for one cycle -> IDLE.
- AluOp: 01 for SUB, 00 for ADD and MAC. Held constant from LOADA through WRITE; 00 in IDLE, CLRB and DONE.
- remaining is loaded with Count at capture; Count=0 is treated as 1 (a single iteration, no wrap to 16).
- Iter saturates at 2^CNT_W-1 and wraps never. It holds its value in DONE and IDLE until the next command capture.
- Latency, with Start accepted at edge k:
  - ADD/SUB: Done high in cycle k+5; Ready again at k+6.
  - MAC with c iterations: Done at k+5+3(c-1).
  - CLR: Done at k+2.
- Strobe exclusivity: at most one of LatchA, LatchB, LatchOut, or ClearB=0 is active in any cycle.

Test Plan:
- Clear=1 for 2 cycles, then Clear=0 -> all outputs at reset values, Ready=1, ClearB=1.
- Op=00, Start pulse at edge 0 -> LatchA@1, LatchB@2 (SelFeedback=0), LatchOut@4, Done@5, Ready@6; AluOp=00 throughout; Iter=1.
- Op=01, Start -> same timing with AluOp=01 during cycles 1-4; Op=11 -> ClearB=0 only in cycle 1, Done@2.
- Op=10, Count=3 -> LatchOut@4,7,10; FEEDBK LatchB with SelFeedback=1 @5,8; Done@11; Iter=3. With A=2 and B=1 loaded, datapath B ends at 7 (1+2+2+2 captured via feedback).
- Op=10, Count=0 -> behaves as a single iteration, Done@5, Iter=1; Start pulses during cycles 1-4 ignored, no second command.
- Op=10, Count=5; assert Clear at cycle 6 -> IDLE at edge 7, all strobes deasserted, Iter=0, no Done pulse. Start together with Clear -> command not captured.
